mcu_framebuffer_bridge: RTL and testbench

- Parametrised MCU-to-framebuffer bridge.
- Accepts asynchronous 8-bit register writes and reads from an external MCU and converts them into handshaked memory write/read transactions toward the memory manager.
- Generalises the single-pixel MCU interface:
  - configurable coordinate widths;
  - write FIFO, so the MCU never waits on memory arbitration;
  - X/Y autoincrement with line wrap;
  - pixel readback;
  - readable status register.

---
 rtl/mcu_framebuffer_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_mcu_framebuffer_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_framebuffer_bridge.sv
// MCU-to-framebuffer bridge: synchronises asynchronous MCU register strobes,
// queues pixel writes in a small FIFO and turns them (and pixel readbacks)
// into handshaked memory transactions.
module mcu_framebuffer_bridge #(
  parameter int unsigned X_BITS      = 9,
  parameter int unsigned Y_BITS      = 8,
  parameter int unsigned X_MAX       = 319,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mcu_chip_select,
  input  logic                     mcu_write_enable,
  input  logic [2:0]               mcu_register_select,
  input  logic [7:0]               mcu_data_in,
  output logic [7:0]               mcu_data_out,
  output logic                     mcu_data_oe,
  output logic [X_BITS+Y_BITS-1:0] memory_address,
  output logic                     memory_write_request,
  output logic [7:0]               memory_write_data,
  input  logic                     memory_write_complete,
  output logic                     memory_read_request,
  input  logic [7:0]               memory_read_data,
  input  logic                     memory_read_complete
);

  localparam int unsigned AddrW  = X_BITS + Y_BITS;
  localparam int unsigned EntryW = AddrW + 8;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StGap} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_prev_q;
  logic                   write_event;

  logic [X_BITS-1:0]      x_q, x_d;
  logic [Y_BITS-1:0]      y_q, y_d;
  logic [7:0]             control_q;
  logic                   overflow_q;
  logic                   read_valid_q;
  logic                   read_pending_q;
  logic [AddrW-1:0]       read_addr_q;
  logic [7:0]             readback_q;

  logic [EntryW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   fifo_full, fifo_empty, push, pop, read_done;
  logic [EntryW-1:0]      fifo_head;

  logic wr_x_low, wr_x_high, wr_y, wr_data, wr_control, wr_status, wr_trigger;
  logic [7:0] read_mux;

  // Strobe synchroniser plus edge detector; one event per strobe assertion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], mcu_chip_select & ~mcu_write_enable};
      strobe_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign write_event = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
  assign wr_x_low    = write_event && (mcu_register_select == 3'd0);
  assign wr_x_high   = write_event && (mcu_register_select == 3'd1);
  assign wr_y        = write_event && (mcu_register_select == 3'd2);
  assign wr_data     = write_event && (mcu_register_select == 3'd3);
  assign wr_control  = write_event && (mcu_register_select == 3'd4);
  assign wr_status   = write_event && (mcu_register_select == 3'd5);
  assign wr_trigger  = write_event && (mcu_register_select == 3'd6);

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A full FIFO drops the push even if the head pops on the same edge.
  assign push       = wr_data && !fifo_full;
  assign pop        = (state_q == StWrite) && memory_write_complete;
  assign read_done  = (state_q == StRead) && memory_read_complete;
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // Cursor next state: direct register writes, then autoincrement on push.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    for (int i = 0; i < int'(X_BITS); i++) begin
      if (wr_x_low && i < 8) x_d[i] = mcu_data_in[i];
      if (wr_x_high && i >= 8 && i < 16) x_d[i] = mcu_data_in[i-8];
    end
    if (wr_y) y_d = Y_BITS'(mcu_data_in);
    if (push && control_q[0]) begin
      if (control_q[1] && x_q == X_BITS'(X_MAX)) begin
        x_d = '0;
        y_d = y_q + Y_BITS'(1);
      end else begin
        x_d = x_q + X_BITS'(1);
      end
    end
  end

  // Register file, status flags and FIFO pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      control_q      <= '0;
      overflow_q     <= 1'b0;
      read_valid_q   <= 1'b0;
      read_pending_q <= 1'b0;
      read_addr_q    <= '0;
      readback_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (wr_control) control_q <= mcu_data_in;
      if (wr_data && fifo_full) overflow_q <= 1'b1;
      else if (wr_status && mcu_data_in[2]) overflow_q <= 1'b0;
      // A completing read wins over a simultaneous clear request.
      if (read_done) read_valid_q <= 1'b1;
      else if (wr_status && mcu_data_in[3]) read_valid_q <= 1'b0;
      if (read_done) begin
        read_pending_q <= 1'b0;
        readback_q     <= memory_read_data;
      end else if (wr_trigger && !read_pending_q) begin
        read_pending_q <= 1'b1;
        read_addr_q    <= {y_q, x_q};
      end
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {y_q, x_q, mcu_data_in};
  end

  // Memory FSM: queued writes first, then a pending read, one idle gap after each.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q              <= StIdle;
      memory_write_request <= 1'b0;
      memory_read_request  <= 1'b0;
      memory_address       <= '0;
      memory_write_data    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q              <= StWrite;
            memory_write_request <= 1'b1;
            memory_address       <= fifo_head[EntryW-1:8];
            memory_write_data    <= fifo_head[7:0];
          end else if (read_pending_q) begin
            state_q             <= StRead;
            memory_read_request <= 1'b1;
            memory_address      <= read_addr_q;
          end
        end
        StWrite: begin
          if (memory_write_complete) begin
            state_q              <= StGap;
            memory_write_request <= 1'b0;
          end
        end
        StRead: begin
          if (memory_read_complete) begin
            state_q             <= StGap;
            memory_read_request <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // MCU read-back mux, zero whenever the chip is not selected.
  always_comb begin
    read_mux = '0;
    case (mcu_register_select)
      3'd0: for (int i = 0; i < int'(X_BITS); i++) if (i < 8) read_mux[i] = x_q[i];
      3'd1: for (int i = 0; i < int'(X_BITS); i++) if (i >= 8 && i < 16) read_mux[i-8] = x_q[i];
      3'd2: for (int i = 0; i < int'(Y_BITS); i++) if (i < 8) read_mux[i] = y_q[i];
      3'd3: read_mux = readback_q;
      3'd4: read_mux = control_q;
      3'd5: read_mux = {3'b000, read_pending_q, read_valid_q, overflow_q, fifo_full, fifo_empty};
      default: read_mux = '0;
    endcase
  end

  assign mcu_data_oe  = mcu_chip_select & mcu_write_enable;
  assign mcu_data_out = mcu_chip_select ? read_mux : 8'h00;

endmodule

// File: tb/tb_mcu_framebuffer_bridge.sv
// Directed testbench for mcu_framebuffer_bridge with hand-computed expectations.
module tb_mcu_framebuffer_bridge;

  localparam int unsigned X_BITS = 9;
  localparam int unsigned Y_BITS = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        mcu_chip_select, mcu_write_enable;
  logic [2:0]  mcu_register_select;
  logic [7:0]  mcu_data_in, mcu_data_out;
  logic        mcu_data_oe;
  logic [16:0] memory_address;
  logic        memory_write_request, memory_write_complete;
  logic [7:0]  memory_write_data;
  logic        memory_read_request, memory_read_complete;
  logic [7:0]  memory_read_data;

  int vectors = 0;
  int miscompares = 0;

  mcu_framebuffer_bridge #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .X_MAX(319), .FIFO_DEPTH(4), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .mcu_chip_select(mcu_chip_select), .mcu_write_enable(mcu_write_enable),
    .mcu_register_select(mcu_register_select), .mcu_data_in(mcu_data_in),
    .mcu_data_out(mcu_data_out), .mcu_data_oe(mcu_data_oe),
    .memory_address(memory_address), .memory_write_request(memory_write_request),
    .memory_write_data(memory_write_data), .memory_write_complete(memory_write_complete),
    .memory_read_request(memory_read_request), .memory_read_data(memory_read_data),
    .memory_read_complete(memory_read_complete)
  );

  always #5 clock = ~clock;

  // MCU write cycle: strobe held for 'hold' clocks, then released long enough to re-arm.
  task automatic mcu_write(input logic [2:0] rs, input logic [7:0] d, input int hold = 4);
    @(negedge clock);
    mcu_register_select = rs;
    mcu_data_in = d;
    mcu_chip_select = 1'b1;
    mcu_write_enable = 1'b0;
    repeat (hold) @(negedge clock);
    mcu_chip_select = 1'b0;
    mcu_write_enable = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic mcu_read(input logic [2:0] rs, output logic [7:0] d, output logic oe);
    @(negedge clock);
    mcu_register_select = rs;
    mcu_chip_select = 1'b1;
    mcu_write_enable = 1'b1;
    #1;
    d = mcu_data_out;
    oe = mcu_data_oe;
    mcu_chip_select = 1'b0;
  endtask

  // Memory-side responder for one write; ok=0 if timeout or a read request came first.
  task automatic serve_write(output bit ok, output logic [16:0] a, output logic [7:0] d,
                             output bit gap_low);
    ok = 1'b0;
    gap_low = 1'b0;
    a = '0;
    d = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (memory_read_request) break;
      if (memory_write_request) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      a = memory_address;
      d = memory_write_data;
      memory_write_complete = 1'b1;
      @(negedge clock);
      memory_write_complete = 1'b0;
      gap_low = !memory_write_request;
      @(negedge clock);
      gap_low = gap_low && !memory_write_request && !memory_read_request;
    end
  endtask

  task automatic serve_read(input logic [7:0] rdata, output bit ok, output logic [16:0] a,
                            output bit dropped);
    ok = 1'b0;
    dropped = 1'b0;
    a = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (memory_write_request) break;
      if (memory_read_request) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      a = memory_address;
      memory_read_data = rdata;
      memory_read_complete = 1'b1;
      @(negedge clock);
      memory_read_complete = 1'b0;
      dropped = !memory_read_request;
    end
  endtask

  // Counts clocks in which any memory request is seen.
  task automatic count_requests(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (memory_write_request || memory_read_request) n++;
    end
  endtask

  task automatic test_reset;
    logic [7:0] rd;
    logic oe;
    vectors++; if (memory_write_request !== 1'b0 || memory_read_request !== 1'b0) begin
      miscompares++; $display("FAIL reset_req: got w=%b r=%b want 0 0", memory_write_request,
                              memory_read_request); end
    vectors++; if (memory_address !== 17'h0) begin
      miscompares++; $display("FAIL reset_addr: got %h want 0", memory_address); end
    vectors++; if (mcu_data_oe !== 1'b0 || mcu_data_out !== 8'h00) begin
      miscompares++; $display("FAIL idle_bus: got oe=%b out=%h want 0 00", mcu_data_oe,
                              mcu_data_out); end
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h01) begin
      miscompares++; $display("FAIL reset_status: got %h want 01", rd); end
    vectors++; if (oe !== 1'b1) begin
      miscompares++; $display("FAIL read_oe: got %b want 1", oe); end
    mcu_read(3'd0, rd, oe);
    vectors++; if (rd !== 8'h00) begin
      miscompares++; $display("FAIL reset_xlow: got %h want 00", rd); end
  endtask

  task automatic test_single_write;
    logic [7:0] rd, d;
    logic oe;
    logic [16:0] a;
    bit ok, gap;
    mcu_write(3'd0, 8'h3F);
    mcu_write(3'd1, 8'h01);
    mcu_write(3'd2, 8'h02);
    mcu_write(3'd7, 8'hFF);
    mcu_read(3'd0, rd, oe);
    vectors++; if (rd !== 8'h3F) begin miscompares++; $display("FAIL xlow: got %h want 3f", rd); end
    mcu_read(3'd1, rd, oe);
    vectors++; if (rd !== 8'h01) begin miscompares++; $display("FAIL xhigh: got %h want 01", rd); end
    mcu_read(3'd2, rd, oe);
    vectors++; if (rd !== 8'h02) begin miscompares++; $display("FAIL y: got %h want 02", rd); end
    mcu_read(3'd7, rd, oe);
    vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL reg7: got %h want 00", rd); end
    mcu_write(3'd3, 8'h55);
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h00) begin
      miscompares++; $display("FAIL status_inflight: got %h want 00", rd); end
    serve_write(ok, a, d, gap);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr1_seen: got 0 want 1"); end
    vectors++; if (a !== {8'h02, 9'h13F}) begin
      miscompares++; $display("FAIL wr1_addr: got %h want %h", a, {8'h02, 9'h13F}); end
    vectors++; if (d !== 8'h55) begin miscompares++; $display("FAIL wr1_data: got %h want 55", d); end
    vectors++; if (!gap) begin miscompares++; $display("FAIL wr1_gap: got 0 want 1"); end
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h01) begin
      miscompares++; $display("FAIL status_drained: got %h want 01", rd); end
  endtask

  task automatic test_autoincrement_wrap;
    logic [16:0] exp_a [3];
    logic [7:0] rd, d;
    logic oe;
    logic [16:0] a;
    bit ok, gap;
    exp_a[0] = {8'd5, 9'd318};
    exp_a[1] = {8'd5, 9'd319};
    exp_a[2] = {8'd6, 9'd0};
    mcu_write(3'd4, 8'h03);
    mcu_write(3'd0, 8'h3E);
    mcu_write(3'd1, 8'h01);
    mcu_write(3'd2, 8'h05);
    for (int i = 0; i < 3; i++) mcu_write(3'd3, 8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      serve_write(ok, a, d, gap);
      vectors++; if (!ok || a !== exp_a[i] || d !== 8'hA0 + 8'(i)) begin
        miscompares++; $display("FAIL wrap_wr%0d: got ok=%b a=%h d=%h want 1 %h %h", i, ok, a, d,
                                exp_a[i], 8'hA0 + 8'(i)); end
    end
    mcu_read(3'd0, rd, oe);
    vectors++; if (rd !== 8'h01) begin miscompares++; $display("FAIL wrap_x: got %h want 01", rd); end
    mcu_read(3'd2, rd, oe);
    vectors++; if (rd !== 8'h06) begin miscompares++; $display("FAIL wrap_y: got %h want 06", rd); end
    mcu_read(3'd4, rd, oe);
    vectors++; if (rd !== 8'h03) begin miscompares++; $display("FAIL control: got %h want 03", rd); end
  endtask

  task automatic test_overflow;
    logic [7:0] rd, d;
    logic oe;
    logic [16:0] a;
    bit ok, gap;
    mcu_write(3'd4, 8'h01);
    mcu_write(3'd0, 8'h10);
    mcu_write(3'd1, 8'h00);
    mcu_write(3'd2, 8'h00);
    for (int i = 0; i < 5; i++) mcu_write(3'd3, 8'h10 + 8'(i));
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h06) begin miscompares++; $display("FAIL ovf_status: got %h want 06", rd); end
    mcu_read(3'd0, rd, oe);
    vectors++; if (rd !== 8'h14) begin
      miscompares++; $display("FAIL ovf_cursor: got %h want 14", rd); end
    for (int i = 0; i < 4; i++) begin
      serve_write(ok, a, d, gap);
      vectors++; if (!ok || a !== {8'h00, 9'h010 + 9'(i)} || d !== 8'h10 + 8'(i)) begin
        miscompares++; $display("FAIL ovf_wr%0d: got ok=%b a=%h d=%h want 1 %h %h", i, ok, a, d,
                                {8'h00, 9'h010 + 9'(i)}, 8'h10 + 8'(i)); end
    end
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h05) begin
      miscompares++; $display("FAIL ovf_drained: got %h want 05", rd); end
    mcu_write(3'd5, 8'h04);
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h01) begin
      miscompares++; $display("FAIL ovf_clear: got %h want 01", rd); end
  endtask

  task automatic test_readback;
    logic [7:0] rd, d;
    logic oe;
    logic [16:0] a;
    bit ok, gap, dropped;
    int n;
    mcu_write(3'd4, 8'h00);
    mcu_write(3'd0, 8'h07);
    mcu_write(3'd1, 8'h00);
    mcu_write(3'd2, 8'h03);
    mcu_write(3'd3, 8'h11);
    mcu_write(3'd3, 8'h22);
    mcu_write(3'd6, 8'h00);
    mcu_write(3'd6, 8'h00);
    for (int i = 0; i < 2; i++) begin
      serve_write(ok, a, d, gap);
      vectors++; if (!ok || a !== {8'd3, 9'd7} || d !== (i == 0 ? 8'h11 : 8'h22)) begin
        miscompares++; $display("FAIL rb_wr%0d: got ok=%b a=%h d=%h want 1 %h %h", i, ok, a, d,
                                {8'd3, 9'd7}, (i == 0 ? 8'h11 : 8'h22)); end
    end
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h11) begin miscompares++; $display("FAIL rb_busy: got %h want 11", rd); end
    serve_read(8'h77, ok, a, dropped);
    vectors++; if (!ok || a !== {8'd3, 9'd7} || !dropped) begin
      miscompares++; $display("FAIL rb_read: got ok=%b a=%h drop=%b want 1 %h 1", ok, a, dropped,
                              {8'd3, 9'd7}); end
    mcu_read(3'd3, rd, oe);
    vectors++; if (rd !== 8'h77) begin miscompares++; $display("FAIL rb_data: got %h want 77", rd); end
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h09) begin miscompares++; $display("FAIL rb_valid: got %h want 09", rd); end
    count_requests(20, n);
    vectors++; if (n !== 0) begin
      miscompares++; $display("FAIL rb_single: got %0d request cycles want 0", n); end
    mcu_write(3'd5, 8'h08);
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h01) begin miscompares++; $display("FAIL rb_clear: got %h want 01", rd); end
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] rd;
    logic oe;
    int n;
    mcu_write(3'd4, 8'h80);
    mcu_write(3'd0, 8'h22);
    for (int i = 0; i < 3; i++) mcu_write(3'd3, 8'hC0 + 8'(i));
    mcu_read(3'd4, rd, oe);
    vectors++; if (rd !== 8'h80) begin miscompares++; $display("FAIL ctl_bits: got %h want 80", rd); end
    vectors++; if (memory_write_request !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_req: got %b want 1", memory_write_request); end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++; if (memory_write_request !== 1'b0 || memory_address !== 17'h0) begin
      miscompares++; $display("FAIL async_reset: got req=%b a=%h want 0 0", memory_write_request,
                              memory_address); end
    @(negedge clock);
    reset = 1'b0;
    count_requests(20, n);
    vectors++; if (n !== 0) begin
      miscompares++; $display("FAIL post_reset_req: got %0d request cycles want 0", n); end
    mcu_read(3'd5, rd, oe);
    vectors++; if (rd !== 8'h01) begin
      miscompares++; $display("FAIL post_reset_status: got %h want 01", rd); end
    mcu_read(3'd4, rd, oe);
    vectors++; if (rd !== 8'h00) begin
      miscompares++; $display("FAIL post_reset_ctl: got %h want 00", rd); end
    mcu_read(3'd0, rd, oe);
    vectors++; if (rd !== 8'h00) begin
      miscompares++; $display("FAIL post_reset_x: got %h want 00", rd); end
  endtask

  task automatic test_strobe_length;
    int holds [2];
    logic [7:0] d;
    logic [16:0] a;
    bit ok, gap;
    int n;
    holds[0] = 10;
    holds[1] = 3;
    for (int k = 0; k < 2; k++) begin
      mcu_write(3'd3, 8'h5A + 8'(k), holds[k]);
      serve_write(ok, a, d, gap);
      vectors++; if (!ok || a !== 17'h0 || d !== 8'h5A + 8'(k)) begin
        miscompares++; $display("FAIL strobe%0d_push: got ok=%b a=%h d=%h want 1 0 %h", holds[k],
                                ok, a, d, 8'h5A + 8'(k)); end
      count_requests(20, n);
      vectors++; if (n !== 0) begin
        miscompares++; $display("FAIL strobe%0d_once: got %0d extra want 0", holds[k], n); end
    end
  endtask

  initial begin
    reset = 1'b1;
    mcu_chip_select = 1'b0;
    mcu_write_enable = 1'b1;
    mcu_register_select = 3'd0;
    mcu_data_in = 8'h00;
    memory_write_complete = 1'b0;
    memory_read_complete = 1'b0;
    memory_read_data = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_single_write();
    test_autoincrement_wrap();
    test_overflow();
    test_readback();
    test_reset_mid_write();
    test_strobe_length();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
